button_debounce: RTL and testbench



---
 rtl/button_debounce.sv | 104 ++++++++++
 tb/tb_button_debounce.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// button_debounce: synchronise and debounce one raw push-button into a clean level
// plus single-cycle press, release and long-press pulses.
module button_debounce #(
    parameter int clk_freq_hz   = 12_000_000,
    parameter int debounce_ms   = 10,
    parameter int long_press_ms = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn0,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);
    localparam int CYC_PER_MS = clk_freq_hz / 1000;
    localparam int DEB        = CYC_PER_MS * debounce_ms;
    localparam int LONG       = CYC_PER_MS * long_press_ms;
    localparam int DW         = $clog2(DEB + 1);
    localparam int LW         = $clog2(LONG + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB - 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_e;

    state_e        state_q, state_d;
    logic          s1_q, s2_q;
    logic [DW-1:0] deb_q, deb_d;
    logic [LW-1:0] long_q, long_d;
    logic          done_q, done_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          lp_q, lp_d;
    logic          wait_q, wait_d, accept_press, accept_release, long_fire;

    // Two-flop synchroniser for the asynchronous button pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn0;
            s2_q <= s1_q;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            deb_q     <= '0;
            long_q    <= '0;
            done_q    <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            lp_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_q     <= deb_d;
            long_q    <= long_d;
            done_q    <= done_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            lp_q      <= lp_d;
        end
    end

    // Next state: a wait state is left on a bounce or once DEB matching samples are seen
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       state_d = s2_q ? PRESS_WAIT : IDLE;
            PRESS_WAIT: state_d = !s2_q ? IDLE : (deb_q == DEB_LAST ? PRESSED : PRESS_WAIT);
            PRESSED:    state_d = s2_q ? PRESSED : RELEASE_WAIT;
            default:    state_d = s2_q ? PRESSED : (deb_q == DEB_LAST ? IDLE : RELEASE_WAIT);
        endcase
    end

    // Counters and next output values; long_cnt only advances while steadily pressed
    always_comb begin
        wait_q         = (state_q == PRESS_WAIT) || (state_q == RELEASE_WAIT);
        wait_d         = (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
        accept_press   = (state_q == PRESS_WAIT) && (state_d == PRESSED);
        accept_release = (state_q == RELEASE_WAIT) && (state_d == IDLE);
        long_fire      = (state_q == PRESSED) && s2_q && (long_q == LONG_LAST) && !done_q;
        deb_d          = wait_d ? (wait_q ? deb_q + 1'b1 : DW'(1)) : '0;
        long_d         = accept_press ? '0 :
                         ((state_q == PRESSED) && s2_q && (long_q != LONG_MAX)) ? long_q + 1'b1 : long_q;
        done_d         = accept_press ? 1'b0 : (done_q | long_fire);
        level_d        = accept_press ? 1'b1 : (accept_release ? 1'b0 : level_q);
        press_d        = accept_press;
        release_d      = accept_release;
        lp_d           = long_fire;
    end

    assign btn_level        = level_q;
    assign press_pulse      = press_q;
    assign release_pulse    = release_q;
    assign long_press_pulse = lp_q;
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: scoreboard bench comparing the debouncer against a run-length model.
`timescale 1ns/100ps
module tb_button_debounce;
    localparam int DEB  = 10;
    localparam int LONG = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn0 = 1'b0;
    logic btn_level, press_pulse, release_pulse, long_press_pulse;

    typedef struct {int c; int k;} ev_t;
    ev_t ev_q[$];
    ev_t lv_q[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int m_s1, m_s2, m_lvl, m_run, m_held, m_done;

    button_debounce #(.clk_freq_hz(10_000), .debounce_ms(1), .long_press_ms(5)) dut (
        .clk(clk), .rst_n(rst_n), .btn0(btn0), .btn_level(btn_level),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_press_pulse(long_press_pulse)
    );

    always #0.5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: the level flips once DEB consecutive synchronised samples disagree with it;
    // hold time counts samples spent pressed with no release pending.
    task automatic apply(input logic b);
        int samp, k;
        btn0 = b;
        samp = m_s2;
        m_s2 = m_s1;
        m_s1 = int'(b);
        k = 0;
        if (samp != m_lvl) begin
            m_run++;
            if (m_run == DEB) begin
                m_lvl = samp;
                m_run = 0;
                k = m_lvl ? 1 : 2;
                if (m_lvl == 1) begin
                    m_held = 0;
                    m_done = 0;
                end
            end
        end else if (m_run > 0) begin
            m_run = 0;
        end else if (m_lvl == 1) begin
            if (m_held < LONG) m_held++;
            if (m_held == LONG && m_done == 0) begin
                k = 3;
                m_done = 1;
            end
        end
        if (k != 0) ev_q.push_back('{cyc + 1, k});
        lv_q.push_back('{cyc + 1, m_lvl});
    endtask

    task automatic step(input logic b);
        @(negedge clk);
        #0.2;
        apply(b);
    endtask

    task automatic hold(input logic b, input int n);
        repeat (n) step(b);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_level"}, int'(btn_level), 0);
        chk({tag, "_press"}, int'(press_pulse), 0);
        chk({tag, "_release"}, int'(release_pulse), 0);
        chk({tag, "_long"}, int'(long_press_pulse), 0);
    endtask

    task automatic do_reset(input int n, input bit toggle, input logic b_after);
        @(negedge clk);
        #0.2;
        rst_n = 1'b0;
        #0.1;
        chk_zero("reset_now");
        ev_q.delete();
        lv_q.delete();
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_held = 0; m_done = 0;
        repeat (n) begin
            @(negedge clk);
            chk_zero("reset_hold");
            #0.2;
            if (toggle) btn0 = ~btn0;
        end
        @(negedge clk);
        #0.2;
        rst_n = 1'b1;
        apply(b_after);
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a pulse or an expected one is due
    always @(negedge clk) begin
        int kind;
        if (rst_n) begin
            kind = press_pulse ? 1 : release_pulse ? 2 : long_press_pulse ? 3 : 0;
            chk("pulse_onehot0", int'($onehot0({press_pulse, release_pulse, long_press_pulse})), 1);
            while (ev_q.size() > 0 && ev_q[0].c < cyc) begin
                chk("stale_pulse", 0, ev_q[0].k);
                void'(ev_q.pop_front());
            end
            if (ev_q.size() > 0 && ev_q[0].c == cyc) begin
                chk("pulse_kind", kind, ev_q[0].k);
                void'(ev_q.pop_front());
            end else if (kind != 0) begin
                chk("unexpected_pulse", kind, 0);
            end
            while (lv_q.size() > 0 && lv_q[0].c < cyc) void'(lv_q.pop_front());
            if (lv_q.size() > 0 && lv_q[0].c == cyc) begin
                chk("btn_level", int'(btn_level), lv_q[0].k);
                void'(lv_q.pop_front());
            end
        end
    end

    initial begin
        logic b;
        int len;
        do_reset(5, 1'b1, 1'b0);
        hold(1'b0, 20);
        hold(1'b1, 30);
        hold(1'b0, 30);
        hold(1'b1, 1); hold(1'b0, 5);
        hold(1'b1, 3); hold(1'b0, 5);
        hold(1'b1, 9); hold(1'b0, 5);
        hold(1'b1, 30); hold(1'b0, 20);
        hold(1'b1, 100); hold(1'b0, 20);
        hold(1'b1, 32); hold(1'b0, 4); hold(1'b1, 80); hold(1'b0, 20);
        hold(1'b1, 6);
        do_reset(3, 1'b0, 1'b1);
        hold(1'b1, 20);
        do_reset(2, 1'b0, 1'b0);
        hold(1'b0, 20);
        repeat (300) begin
            b = logic'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 70)) : int'($urandom_range(1, 12));
            if ($urandom_range(0, 40) == 0) do_reset(int'($urandom_range(1, 4)), 1'b1, b);
            hold(b, len);
        end
        hold(1'b0, 30);
        chk("queue_drained", ev_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
